// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    // Operation select encodings; op[1] selects divide, op[0] selects unsigned.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Number of iterations per operation.
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = 6;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module md_abs_neg #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] val_i,
    output logic [Width-1:0] val_o
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        val_o = neg_i ? (~val_i + Width'(1)) : val_i;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 iterations, result held in DONE
// until the instruction leaves EXE.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_div_valid,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            mem_stall,
    input  logic            cancel,
    output logic            mul_div_validout,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    import mul_div_unit_pkg::*;

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [31:0]           src1_q, src1_d;    // original dividend, for divide-by-zero
    logic [31:0]           opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [63:0]           acc_q, acc_d;      // product accumulator / partial remainder
    logic [31:0]           quo_q, quo_d;
    logic                  neg_q, neg_d;      // product / quotient sign
    logic                  rem_neg_q, rem_neg_d;
    logic [31:0]           hi_q, hi_d, lo_q, lo_d;

    logic        neg1, neg2;
    logic [31:0] mag1, mag2;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_rem_next;
    logic        div_ge;
    logic [31:0] quo_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign neg1 = md_is_signed(op) & src1[31];
    assign neg2 = md_is_signed(op) & src2[31];

    md_abs_neg #(.Width(32)) u_abs1 (.neg_i(neg1), .val_i(src1), .val_o(mag1));
    md_abs_neg #(.Width(32)) u_abs2 (.neg_i(neg2), .val_i(src2), .val_o(mag2));

    // One shift-add step and one restoring-divide step over the latched magnitudes.
    always_comb begin
        mul_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next     = {mul_sum, acc_q[31:1]};
        div_shift    = {acc_q[31:0], quo_q[31]};
        div_ge       = div_shift >= {1'b0, opnd_q};
        div_rem_next = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
        quo_next     = {quo_q[30:0], div_ge};
    end

    md_abs_neg #(.Width(64)) u_fix_prod (.neg_i(neg_q), .val_i(mul_next), .val_o(prod_fix));
    md_abs_neg #(.Width(32)) u_fix_quo (.neg_i(neg_q), .val_i(quo_next), .val_o(quo_fix));
    md_abs_neg #(.Width(32)) u_fix_rem (.neg_i(rem_neg_q), .val_i(div_rem_next[31:0]),
                                        .val_o(rem_fix));

    // Next-state: FSM, operand latch, iteration and final result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        src1_d    = src1_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (cancel) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mul_div_valid) begin
                        state_d   = StBusy;
                        cnt_d     = '0;
                        op_d      = op;
                        src1_d    = src1;
                        opnd_d    = md_is_div(op) ? mag2 : mag1;
                        acc_d     = md_is_div(op) ? 64'd0 : {32'd0, mag2};
                        quo_d     = mag1;
                        neg_d     = neg1 ^ neg2;
                        rem_neg_d = neg1;
                    end
                end
                StBusy: begin
                    cnt_d = cnt_q + MD_CNT_W'(1);
                    if (md_is_div(op_q)) begin
                        acc_d = {31'd0, div_rem_next};
                        quo_d = quo_next;
                    end else begin
                        acc_d = mul_next;
                    end
                    if (cnt_q == MD_CNT_W'(MD_ITER - 1)) begin
                        state_d = StDone;
                        if (!md_is_div(op_q)) begin
                            {hi_d, lo_d} = prod_fix;
                        end else if (opnd_q == 32'd0) begin
                            hi_d = src1_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end
                end
                StDone: begin
                    if (!mem_stall) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            src1_q    <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Flags decode the state register only, so no input reaches them combinationally.
    assign mul_div_validout = (state_q == StDone);
    assign busy             = (state_q == StBusy);
    assign hi               = hi_q;
    assign lo               = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, random ops against an
// arithmetic reference model, and hand-written stall/cancel/reset sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_div_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        mem_stall = 1'b0;
    logic        cancel = 1'b0;
    logic        mul_div_validout;
    logic        busy;
    logic [31:0] hi, lo;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .mul_div_valid   (mul_div_valid),
        .op              (op),
        .src1            (src1),
        .src2            (src2),
        .mem_stall       (mem_stall),
        .cancel          (cancel),
        .mul_div_validout(mul_div_validout),
        .busy            (busy),
        .hi              (hi),
        .lo              (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with divide-by-zero rule.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (o == MD_MULT) begin
            p = sa * sb;
        end else if (o == MD_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (o == MD_DIVU) begin
            p = {a % b, a / b};
        end else begin
            p = {32'(sa % sb), 32'(sa / sb)};
        end
        return p;
    endfunction

    task automatic start_op(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        mul_div_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        tick();
        check({name, " accepted"}, 64'(busy), 64'd1);
    endtask

    // Waits for validout (bounded), checks latency and result; leaves DUT in DONE.
    task automatic finish_op(input string name, input logic [63:0] exp, input bit scramble);
        int cyc = 1;
        while (!mul_div_validout && cyc < 40) begin
            if (scramble) begin
                src1 = $urandom;
                src2 = $urandom;
                op = 2'($urandom);
            end
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'd33);
        check({name, " result"}, {hi, lo}, exp);
        mul_div_valid = 1'b0;
    endtask

    task automatic leave_done(input string name);
        tick();
        check({name, " back to idle"}, {62'd0, mul_div_validout, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;

        tbl[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1]  = '{MD_MULTU, 32'hFFFF_FFFD, 32'd5,        32'h0000_0004, 32'hFFFF_FFF1};
        tbl[2]  = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        tbl[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4]  = '{MD_DIV,   32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
        tbl[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        tbl[6]  = '{MD_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
        tbl[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[8]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        tbl[9]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        tbl[10] = '{MD_DIV,   32'h8000_0000, 32'd1,        32'd0,         32'h8000_0000};

        // Reset state.
        tick();
        tick();
        check("reset state", {30'd0, mul_div_validout, busy, hi, lo}, 64'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            start_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
            finish_op($sformatf("tbl%0d", i), {tbl[i].hi, tbl[i].lo}, 1'b0);
            leave_done($sformatf("tbl%0d", i));
        end

        // Random ops, operands scrambled every BUSY cycle.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            start_op($sformatf("rnd%0d", i), ro, ra, rb);
            finish_op($sformatf("rnd%0d", i), ref_model(ro, ra, rb), 1'b1);
            leave_done($sformatf("rnd%0d", i));
        end

        // Hold DONE for 3 stalled cycles, then a back-to-back op.
        start_op("stall", MD_MULTU, 32'd3, 32'd7);
        finish_op("stall", 64'd21, 1'b0);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall hold%0d", k), {31'd0, mul_div_validout, hi}, {31'd0, 1'b1, 32'd0});
            check($sformatf("stall lo%0d", k), 64'(lo), 64'd21);
        end
        mem_stall = 1'b0;
        mul_div_valid = 1'b1;
        op = MD_DIVU;
        src1 = 32'd1000;
        src2 = 32'd10;
        tick();
        check("b2b idle", {62'd0, mul_div_validout, busy}, 64'd0);
        tick();
        check("b2b accepted", 64'(busy), 64'd1);
        finish_op("b2b", {32'd0, 32'd100}, 1'b0);
        leave_done("b2b");

        // Cancel at counter 10.
        start_op("cancel", MD_MULT, 32'd1234, 32'd5678);
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        mul_div_valid = 1'b0;
        check("cancel idle", {62'd0, mul_div_validout, busy}, 64'd0);
        check("cancel keeps hi/lo", {hi, lo}, {32'd0, 32'd100});
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mul_div_validout) seen = 1'b1;
        end
        check("cancel no validout", 64'(seen), 64'd0);

        // Reset mid-BUSY.
        start_op("rst", MD_DIVU, 32'd99, 32'd4);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mul_div_valid = 1'b0;
        check("rst mid busy", {30'd0, mul_div_validout, busy, hi, lo}, 64'd0);

        // Recovery after reset.
        start_op("post rst", tbl[3].op, tbl[3].a, tbl[3].b);
        finish_op("post rst", {tbl[3].hi, tbl[3].lo}, 1'b1);
        leave_done("post rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the EXE stage. Executes MULT, MULTU, DIV, DIVU and delivers the 64-bit result as HI/LO. Its `mul_div_validout` is the completion flag the pipeline stall logic consumes: EXE stays stalled while a mul/div instruction is in EXE and `mul_div_validout` is low. The result is held stable until the instruction leaves EXE.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mul_div_valid  in  1  a mul/div instruction is present in EXE (the EXE mul/div type flag).
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src1  in  32  rs operand; dividend for divides.
- src2  in  32  rt operand; divisor for divides.
- mem_stall  in  1  MEM is stalled, so the EXE instruction cannot leave this cycle.
- cancel  in  1  flush of the EXE instruction (exception or redirect).
- mul_div_validout  out  1  result valid; high only in DONE.
- busy  out  1  high in BUSY.
- hi  out  32  HI result: product[63:32] or remainder.
- lo  out  32  LO result: product[31:0] or quotient.

## Operation
- FSM states are IDLE, BUSY and DONE.
- Reset: state IDLE; counter 0; hi = lo = 0; validout = 0; busy = 0.
- IDLE → BUSY: taken when mul_div_valid && !cancel.
  - src1, src2 and op are latched.
  - Each operand is converted to its magnitude when op is signed (MULT/DIV) and that operand is negative.
  - The result sign is latched. For MULT it is sign1^sign2. For DIV the quotient sign is sign1^sign2 and the remainder sign is sign1.
  - The counter is cleared.
- BUSY: one iteration per cycle, 32 iterations, counter runs 0..31.
  - Multiply: shift-add on a 64-bit accumulator over the magnitudes.
  - Divide: restoring division giving a 33-bit partial remainder and a 32-bit quotient.
  - On counter 31, sign correction (two's-complement negate) is applied and the result is registered into hi/lo. State → DONE.
- DONE: validout = 1; hi and lo are held.
  - If !mem_stall, state → IDLE on the next edge.
  - If mem_stall, DONE is held with identical outputs.
- cancel: in any state, state → IDLE on the next edge. validout is never asserted for a cancelled operation. hi/lo keep their last values.
- Priority: rst > cancel > normal transitions.
- Divide by zero: hi = src1 (original, unsigned-interpreted), lo = 0xFFFFFFFF, for both DIV and DIVU. This is deterministic and does not raise an exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. Wrap-around, no trap.
- Widths:
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.
  - Negation is 64-bit for products and 32-bit for quotient and remainder.
- mul_div_valid is not sampled in BUSY or DONE. Operands changing mid-operation have no effect.

## Timing
- Start accepted at edge E0: BUSY during cycles 1..32; DONE from cycle 33. validout is first high 33 cycles after acceptance.
- Fixed latency of 33 cycles for all ops. There is no early termination.
- Back-to-back: DONE with !mem_stall → IDLE. The next mul/div, now in EXE, is accepted that IDLE cycle. Minimum spacing is 34 cycles per op.
- The stall unit sees validout combinationally from the state register. validout has no combinational path from any input.

## Structure
- Shared package contents:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
  - FSM state enum (IDLE/BUSY/DONE).
  - MD_ITER = 32.
- One sub-module is natural: md_abs_neg, a combinational conditional two's-complement at 32/64 bits. It is used for operand magnitude and result sign fix.
- Everything else lives in one file: FSM, 6-bit counter, 64-bit accumulator/remainder, 32-bit quotient register.

## Test plan
- MULT src1=0xFFFFFFFD (−3), src2=5 → validout rises exactly 33 cycles after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU of the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9 (−7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by 0 with src1=0x12345678 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Complete an op with mem_stall high for 3 cycles in DONE → validout, hi and lo constant for 4 cycles, then IDLE. A second op presented immediately is accepted the next cycle.
- cancel in BUSY at counter 10 → IDLE next cycle; busy=0; validout never high. rst asserted mid-BUSY → all outputs 0 the next cycle.
- Change src1/src2 every cycle during BUSY → result equals that of the operands latched at acceptance.
